instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 66 ++++++
 tb/tb_instr_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory port, redirect request and the decode-side
// valid/ready output. The slave modport is the fetch unit; master is its environment.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport slave (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport master (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register driving a combinational instruction memory and a
// small {pc, instr} FIFO toward decode, with redirect flush and synchronous reset.
module instr_fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_head, r_tail;
  logic [31:0]   r_mem_pc    [FIFO_DEPTH];
  logic [31:0]   r_mem_instr [FIFO_DEPTH];

  logic w_valid, w_pop, w_push;

  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid && bus.out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still streams at one per cycle.
  assign w_push  = !bus.redirect_valid && ((r_cnt < DEPTH_C) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= {START_ADDR[31:2], 2'b00};
      r_cnt  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else if (bus.redirect_valid) begin
      r_pc   <= {bus.redirect_pc[31:2], 2'b00};
      r_cnt  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'd4;
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is data only; validity comes from r_cnt, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_tail]    <= r_pc;
      r_mem_instr[r_tail] <= bus.imem_instr;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_instr = w_valid ? r_mem_instr[r_head] : NOP;
  assign bus.out_pc    = w_valid ? r_mem_pc[r_head]    : 32'h0;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reference scoreboard of expected {pc, instr}
// plus directed checks for streaming, backpressure, redirect, wrap and mid-run reset.
module tb_instr_fetch;
  localparam logic [31:0] START = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  instr_fetch_if bus();

  always #5 clk = ~clk;
  assign bus.imem_instr = bus.imem_addr ^ 32'hA5A5_0000;

  instr_fetch #(.START_ADDR(START), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];   // expected pcs in FIFO order; instr derived from memory model
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at negedge: compare DUT against the model state.
  task automatic check_all();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, sb_q.size() != 0});
    if (sb_q.size() != 0) begin
      chk("out_pc",    bus.out_pc,    sb_q[0]);
      chk("out_instr", bus.out_instr, sb_q[0] ^ 32'hA5A5_0000);
    end else begin
      chk("idle_pc",    bus.out_pc,    32'h0);
      chk("idle_instr", bus.out_instr, NOP);
    end
  endtask

  // Drive one cycle from a negedge, advance the model, land on the next negedge and check.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit pop;
    rst = r; bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.out_ready = rdy;
    pop = (sb_q.size() != 0) && rdy;
    if (r) begin
      sb_q.delete(); m_pc = START;
    end else if (rv) begin
      sb_q.delete(); m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (sb_q.size() < DEPTH || pop) begin
        sb_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  logic [31:0] h_pc, h_addr;

  initial begin
    rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    m_pc = START;
    @(negedge clk);
    // reset state, with redirect asserted to show rst overrides it
    cyc(1, 1, 32'h0000_0500, 1);
    chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_addr",  bus.imem_addr, START);
    chk("rst_instr", bus.out_instr, NOP);

    // streaming: one instruction per cycle from pc 0
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1);
      chk("stream_pc", bus.out_pc, START + 32'(4 * i));
    end

    // backpressure after reset
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    chk("bp_addr", bus.imem_addr, 32'h8);
    chk("bp_head", bus.out_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_seq", bus.out_pc, 32'(4 * i));
      cyc(0, 0, 0, 1);
    end

    // redirect with a full FIFO; target low bits are dropped
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h0000_0103, 0);
    chk("rd_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rd_addr",  bus.imem_addr, 32'h100);
    cyc(0, 0, 0, 1);
    chk("rd_pc", bus.out_pc, 32'h100);

    // simultaneous push/pop while full
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    h_pc = bus.out_pc; h_addr = bus.imem_addr;
    cyc(0, 0, 0, 1);
    chk("pp_head", bus.out_pc, h_pc + 32'd4);
    chk("pp_addr", bus.imem_addr, h_addr + 32'd4);
    chk("pp_valid", {31'b0, bus.out_valid}, 32'h1);

    // address wrap
    cyc(0, 1, 32'hFFFF_FFF8, 1);
    cyc(0, 0, 0, 1); chk("wrap0", bus.out_pc, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1); chk("wrap1", bus.out_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1); chk("wrap2", bus.out_pc, 32'h0000_0000);
    cyc(0, 0, 0, 1); chk("wrap3", bus.out_pc, 32'h0000_0004);

    // reset mid-run at pc 0x40 with a full FIFO
    cyc(0, 1, 32'h0000_0038, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("mr_pre_addr", bus.imem_addr, 32'h40);
    cyc(1, 0, 0, 1);
    chk("mr_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("mr_addr",  bus.imem_addr, START);
    cyc(0, 0, 0, 1);
    chk("mr_first", bus.out_pc, START);

    // random ready and occasional redirects against the scoreboard
    for (int i = 0; i < 60; i++)
      cyc(0, ($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1) == 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
